// File: rtl/pixel_fetch.sv
// Prefetches one frame of pixels from image memory into a small FIFO
// and hands one byte per consumed pixel to the pixel pusher.
module pixel_fetch #(
    parameter int IMG_W = 480,
    parameter int IMG_H = 480,
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        vs,
    input  logic        vid,
    input  logic [9:0]  hcount,
    output logic        mem_en,
    output logic [17:0] mem_addr,
    input  logic [7:0]  mem_data,
    output logic [7:0]  pixel,
    output logic        underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [17:0] LAST_ADDR = 18'(IMG_W * IMG_H - 1);
    localparam logic [10:0] W_LIM = 11'(IMG_W);
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic          vs_q;
    logic [7:0]    fifo [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   occupancy;
    logic          in_flight;
    logic [17:0]   next_addr;
    logic [17:0]   last_addr;
    logic          frame_start;
    logic          issue;
    logic          consume;
    logic          push;
    logic          pop;

    assign frame_start = vs_q & ~vs;
    // A read in flight already owns a FIFO slot.
    assign occupancy = count + {{AW{1'b0}}, in_flight};
    assign issue = reset & (state == S_RUN) & enable & ~frame_start
                 & (occupancy < DEPTH_L);
    assign consume = enable & vid & ({1'b0, hcount} < W_LIM)
                   & (state != S_IDLE);
    assign push = in_flight & ~frame_start;
    assign pop = consume & (count != '0);

    assign mem_en = issue;
    assign mem_addr = issue ? next_addr : last_addr;

    always_ff @(posedge clk) begin
        if (reset && push) begin
            fifo[wr_ptr] <= mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            vs_q      <= 1'b1;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            in_flight <= 1'b0;
            next_addr <= '0;
            last_addr <= '0;
            pixel     <= 8'h00;
            underflow <= 1'b0;
        end else begin
            vs_q  <= vs;
            pixel <= pop ? fifo[rd_ptr] : 8'h00;
            if (consume && count == '0 && state == S_RUN) begin
                underflow <= 1'b1;
            end
            if (frame_start) begin
                state     <= S_RUN;
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                count     <= '0;
                in_flight <= 1'b0;
                next_addr <= '0;
            end else begin
                in_flight <= issue;
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                if (issue) begin
                    last_addr <= next_addr;
                    next_addr <= next_addr + 1'b1;
                    if (next_addr == LAST_ADDR) begin
                        state <= S_DONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_fetch.sv
// Bench for pixel_fetch: queue-based reference model plus directed
// checks, and a tiny 4x2 instance for the end-of-frame behaviour.
module tb_pixel_fetch;

    logic        clk = 1'b0;
    logic        reset, enable, vs, vid;
    logic [9:0]  hcount;
    logic        mem_en;
    logic [17:0] mem_addr;
    logic [7:0]  mem_data = 8'h00;
    logic [7:0]  pixel;
    logic        underflow;

    logic        s_reset, s_enable, s_vs, s_vid;
    logic [9:0]  s_hcount;
    logic        s_mem_en;
    logic [17:0] s_mem_addr;
    logic [7:0]  s_mem_data = 8'h00;
    logic [7:0]  s_pixel;
    logic        s_underflow;

    int total = 0;
    int bad = 0;
    bit chk_on = 0;

    always #5 clk = ~clk;

    pixel_fetch dut (
        .clk(clk), .reset(reset), .enable(enable), .vs(vs),
        .vid(vid), .hcount(hcount), .mem_en(mem_en),
        .mem_addr(mem_addr), .mem_data(mem_data),
        .pixel(pixel), .underflow(underflow)
    );

    pixel_fetch #(.IMG_W(4), .IMG_H(2), .DEPTH(16)) sdut (
        .clk(clk), .reset(s_reset), .enable(s_enable), .vs(s_vs),
        .vid(s_vid), .hcount(s_hcount), .mem_en(s_mem_en),
        .mem_addr(s_mem_addr), .mem_data(s_mem_data),
        .pixel(s_pixel), .underflow(s_underflow)
    );

    // Image memory: byte at address a is a[7:0], one cycle latency.
    always @(posedge clk) begin
        mem_data <= mem_en ? mem_addr[7:0] : 8'hA5;
        s_mem_data <= s_mem_en ? s_mem_addr[7:0] : 8'h5A;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: 0 idle, 1 run, 2 done.
    int         m_state = 0;
    bit         m_vsq = 1;
    logic [7:0] q[$];
    int         m_next = 0;
    int         m_last = 0;
    bit         m_inf = 0;
    int         m_inf_addr = 0;
    logic [7:0] m_pix = 0;
    bit         m_uf = 0;

    always @(negedge clk) begin
        bit fs, iss, cons;
        fs = m_vsq && !vs;
        iss = reset && m_state == 1 && enable && !fs
            && (q.size() + int'(m_inf) < 16);
        cons = enable && vid && hcount < 480 && m_state != 0;
        if (chk_on) begin
            chk("pixel", pixel, m_pix);
            chk("underflow", underflow, m_uf);
            chk("mem_en", mem_en, iss);
            chk("mem_addr", mem_addr, iss ? m_next : m_last);
        end
        if (!reset) begin
            m_state = 0; m_vsq = 1; q.delete(); m_next = 0;
            m_last = 0; m_inf = 0; m_pix = 0; m_uf = 0;
        end else begin
            m_pix = 0;
            if (cons) begin
                if (q.size() > 0) m_pix = q.pop_front();
                else if (m_state == 1) m_uf = 1;
            end
            if (fs) begin
                q.delete(); m_next = 0; m_inf = 0; m_state = 1;
            end else begin
                if (m_inf) q.push_back(8'(m_inf_addr));
                if (iss) begin
                    if (m_next == 480 * 480 - 1) m_state = 2;
                    m_last = m_next;
                    m_inf_addr = m_next;
                    m_next++;
                end
                m_inf = iss;
            end
            m_vsq = vs;
        end
    end

    initial begin
        int n, mx;
        bit found;
        reset = 0; enable = 0; vs = 1; vid = 0; hcount = 0;
        s_reset = 0; s_enable = 0; s_vs = 1; s_vid = 0; s_hcount = 0;
        repeat (3) tick();
        chk_on = 1;
        @(negedge clk);
        chk("rst_pixel", pixel, 0);
        chk("rst_uf", underflow, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 0);

        tick(); reset = 1; enable = 1;
        n = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (mem_en) n++;
        end
        chk("idle_no_read", n, 0);

        tick(); vs = 0;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (mem_en) n++;
        end
        chk("fill_reads", n, 16);

        for (int h = 0; h < 480; h++) begin
            tick(); vid = 1; hcount = 10'(h);
        end
        tick(); vid = 0;
        @(negedge clk);
        chk("line_uf", underflow, 0);

        tick(); vid = 1; hcount = 500;
        repeat (4) tick();
        vid = 0;

        for (int i = 0; i < 400; i++) begin
            tick();
            enable = ($urandom_range(0, 7) != 0);
            vid = ($urandom_range(0, 3) == 0);
            hcount = 10'($urandom_range(0, 520));
        end
        tick(); enable = 1; vid = 0;
        @(negedge clk);
        chk("uf_pre", underflow, 0);

        tick(); vs = 1;
        tick(); vs = 0;
        tick(); vid = 1; hcount = 0;
        tick(); vid = 0;
        @(negedge clk);
        chk("uf_set", underflow, 1);

        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick(); vid = 1; hcount = 10'(i % 480); vs = 1;
            @(negedge clk);
            if (mem_en && mem_addr == 37) found = 1;
        end
        chk("addr37_seen", found, 1);
        tick(); vs = 0; vid = 0;
        tick();
        @(negedge clk);
        chk("restart_en", mem_en, 1);
        chk("restart_addr", mem_addr, 0);
        chk("uf_sticky", underflow, 1);

        repeat (6) tick();
        reset = 0; vs = 1;
        tick(); reset = 1;
        tick(); vid = 1; hcount = 3;
        repeat (3) tick();
        @(negedge clk);
        chk("uf_rst", underflow, 0);
        tick(); vs = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            hcount = 10'($urandom_range(0, 500));
        end
        tick(); vid = 0;

        tick(); s_reset = 1; s_enable = 1;
        tick(); s_vs = 0;
        n = 0; mx = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (s_mem_en) begin
                n++;
                if (int'(s_mem_addr) > mx) mx = int'(s_mem_addr);
            end
        end
        chk("small_reads", n, 8);
        chk("small_max", mx, 7);
        tick(); s_vid = 1; s_hcount = 0;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("small_pixel", s_pixel, i < 8 ? i : 0);
        end
        chk("small_uf", s_underflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
